uart_baud_detect: RTL

Autobaud detector, the measuring counterpart of the baud enable generator. It times the edges of a 0x55 sync character ('U') on the incoming rx line and reports the bit period in uart_clk cycles. Sits beside the UART RX path. The host or a downstream generator uses baud_period to retune to the far end's rate.

---
 rtl/uart_baud_detect_pkg.sv | 47 ++++
 rtl/uart_rx_sync.sv | 27 ++
 rtl/uart_baud_detect.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_baud_detect_pkg.sv
// Shared types and derived constants for the autobaud detector.
// Width math follows the codebase clogb2 convention (bits needed to hold a value).
package uart_baud_detect_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_MEASURE = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERR     = 3'd4
  } baud_state_e;

  function automatic int clogb2(input int value);
    int r;
    int v;
    r = 32'sd0;
    v = value;
    while (v > 32'sd0) begin
      r = r + 32'sd1;
      v = v >>> 1;
    end
    return r;
  endfunction

  function automatic int max_count_f(input int clk_hz, input int min_baud);
    return 32'sd2 * (clk_hz / min_baud);
  endfunction

  function automatic int min_count_f(input int clk_hz, input int max_baud);
    return clk_hz / max_baud;
  endfunction

  function automatic int period_f(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic int count_width_f(input int max_count);
    return clogb2(max_count) + 32'sd1;
  endfunction

  // Values for the default parameter set
  localparam int DEF_MAX_COUNT = max_count_f(32'sd2000000, 32'sd1200);
  localparam int DEF_MIN_COUNT = min_count_f(32'sd2000000, 32'sd500000);
  localparam int DEF_CW        = count_width_f(DEF_MAX_COUNT);
  localparam int DEF_PERIOD    = period_f(32'sd2000000, 32'sd115200);

endpackage

// File: rtl/uart_rx_sync.sv
// rx synchroniser: two metastability flops plus an edge-reference flop.
// Resets to idle-high so no spurious edge follows reset release.
module uart_rx_sync (
  input  logic uart_clk,
  input  logic uart_rstn,
  input  logic rx,
  output logic rx_sync,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_r;

  // shift the pin through sync1 -> sync2 -> sync3
  always_ff @(posedge uart_clk or negedge uart_rstn) begin
    if (!uart_rstn) begin
      sync_r <= 3'b111;
    end else begin
      sync_r <= {sync_r[1:0], rx};
    end
  end

  assign rx_sync = sync_r[1];
  assign rise    = sync_r[1] & ~sync_r[2];
  assign fall    = ~sync_r[1] & sync_r[2];

endmodule

// File: rtl/uart_baud_detect.sv
// Autobaud detector: times the ten edges of a 0x55 sync character and reports
// the rounded average bit period (intervals 2..9) in uart_clk cycles.
module uart_baud_detect
  import uart_baud_detect_pkg::*;
#(
  parameter int BAUD_CLOCK_SPEED = 2000000,
  parameter int DEFAULT_BAUD     = 115200,
  parameter int MIN_BAUD         = 1200,
  parameter int MAX_BAUD         = 500000,
  parameter int TOL_SHIFT        = 3,
  localparam int MAX_COUNT       = max_count_f(BAUD_CLOCK_SPEED, MIN_BAUD),
  localparam int MIN_COUNT       = min_count_f(BAUD_CLOCK_SPEED, MAX_BAUD),
  localparam int DEFAULT_PERIOD  = period_f(BAUD_CLOCK_SPEED, DEFAULT_BAUD),
  localparam int CW              = count_width_f(MAX_COUNT)
) (
  input  logic          uart_clk,
  input  logic          uart_rstn,
  input  logic          rx,
  input  logic          detect_en,
  output logic [CW-1:0] baud_period,
  output logic          baud_valid,
  output logic          baud_err,
  output logic          busy
);

  localparam int SW = CW + 3;
  localparam logic [CW-1:0] CNT_ONE    = CW'(32'd1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(MAX_COUNT);
  localparam logic [CW-1:0] CNT_MIN    = CW'(MIN_COUNT);
  localparam logic [CW-1:0] PERIOD_RST = CW'(DEFAULT_PERIOD);

  logic          rx_sync_s, rise_s, fall_s, edge_s;
  baud_state_e   state_r, state_next_s;
  logic [CW-1:0] cnt_r, ref_r, diff_s, tol_s;
  logic [SW-1:0] sum_r, rounded_s;
  logic [3:0]    ivl_idx_r;
  logic          ivl_bad_s;

  uart_rx_sync u_rx_sync (
    .uart_clk  (uart_clk),
    .uart_rstn (uart_rstn),
    .rx        (rx),
    .rx_sync   (rx_sync_s),
    .rise      (rise_s),
    .fall      (fall_s)
  );

  assign edge_s    = rise_s | fall_s;
  assign diff_s    = (cnt_r > ref_r) ? (cnt_r - ref_r) : (ref_r - cnt_r);
  assign tol_s     = ref_r >> TOL_SHIFT;
  assign ivl_bad_s = (cnt_r < CNT_MIN) || ((ivl_idx_r != 4'd0) && (diff_s > tol_s));
  assign rounded_s = sum_r + SW'(32'd4);

  // state register
  always_ff @(posedge uart_clk or negedge uart_rstn) begin
    if (!uart_rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next-state: detect_en abort beats edges, edges beat the timeout
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (detect_en && rx_sync_s) state_next_s = ST_ARMED;
        else                        state_next_s = ST_IDLE;
      end
      ST_ARMED: begin
        if (!detect_en)  state_next_s = ST_IDLE;
        else if (fall_s) state_next_s = ST_MEASURE;
        else             state_next_s = ST_ARMED;
      end
      ST_MEASURE: begin
        if (!detect_en) begin
          state_next_s = ST_IDLE;
        end else if (edge_s) begin
          if (ivl_bad_s)               state_next_s = ST_ERR;
          else if (ivl_idx_r == 4'd8)  state_next_s = ST_DONE;
          else                         state_next_s = ST_MEASURE;
        end else if (cnt_r == CNT_MAX) begin
          state_next_s = ST_ERR;
        end else begin
          state_next_s = ST_MEASURE;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      ST_ERR:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // interval counter: restarts at 1 on every edge, saturates at MAX_COUNT
  always_ff @(posedge uart_clk or negedge uart_rstn) begin
    if (!uart_rstn) begin
      cnt_r <= '0;
    end else if (edge_s) begin
      cnt_r <= CNT_ONE;
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // first interval becomes the reference, the rest are summed
  always_ff @(posedge uart_clk or negedge uart_rstn) begin
    if (!uart_rstn) begin
      ref_r     <= '0;
      sum_r     <= '0;
      ivl_idx_r <= 4'd0;
    end else if ((state_r == ST_ARMED) && fall_s) begin
      sum_r     <= '0;
      ivl_idx_r <= 4'd0;
    end else if ((state_r == ST_MEASURE) && edge_s) begin
      if (ivl_idx_r == 4'd0) ref_r <= cnt_r;
      else                   sum_r <= sum_r + {3'b000, cnt_r};
      ivl_idx_r <= ivl_idx_r + 4'd1;
    end else begin
      ref_r     <= ref_r;
      sum_r     <= sum_r;
      ivl_idx_r <= ivl_idx_r;
    end
  end

  // registered result and status outputs
  always_ff @(posedge uart_clk or negedge uart_rstn) begin
    if (!uart_rstn) begin
      baud_period <= PERIOD_RST;
      baud_valid  <= 1'b0;
      baud_err    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      baud_valid <= (state_r == ST_DONE);
      baud_err   <= (state_r == ST_ERR);
      busy       <= (state_next_s == ST_MEASURE);
      if (state_r == ST_DONE) baud_period <= CW'(rounded_s >> 3);
      else                    baud_period <= baud_period;
    end
  end

endmodule
